// File: rtl/enc_pkg.sv
// Shared definitions for the encoder counter readout path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package enc_pkg;

    // Snapshot width shared with the encoder counter top.
    localparam int CNT_W_DEF = 64;

    // Channel identifiers as carried on O_CH.
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Output scheduler states.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/enc_slot.sv
// One-entry snapshot holding slot with a saturating overrun counter.
// Latency: snapshot visible (full=1) the cycle after its rdy pulse.
// Backpressure: a full slot that is not being taken discards the new snapshot and counts a drop.
module enc_slot
    import enc_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              arm,
    input  logic              arm_rise,
    input  logic              take,
    input  logic [CNT_W-1:0]  snap_cnt,
    input  logic              snap_ovf,
    output logic              full,
    output logic [CNT_W-1:0]  data,
    output logic              ovf,
    output logic [DROP_W-1:0] drop
);

    logic              full_q, full_d;
    logic [CNT_W-1:0]  data_q, data_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    // Capture, release and overrun accounting for the slot.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (!arm) begin
            // Disarmed: pending snapshot is flushed and new pulses are ignored.
            full_d = 1'b0;
        end else begin
            if (take) begin
                full_d = 1'b0;
            end
            if (rdy) begin
                // A slot being drained this cycle can accept the new snapshot.
                if (!full_q || take) begin
                    full_d = 1'b1;
                    data_d = snap_cnt;
                    ovf_d  = snap_ovf;
                end else if (drop_q != '1) begin
                    drop_d = drop_q + DROP_W'(1);
                end
            end
        end
        if (arm_rise) begin
            drop_d = '0;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    assign full = full_q;
    assign data = data_q;
    assign ovf  = ovf_q;
    assign drop = drop_q;

endmodule

// File: rtl/enc_readout_arb.sv
// Round-robin readout of two encoder snapshot slots onto one valid/ready stream.
// Latency: rdy pulse in cycle N gives O_VALID in cycle N+2 when idle; one word per cycle sustained.
// Backpressure: output word held stable until O_VALID & I_READY; slots absorb one snapshot each, then drop.
module enc_readout_arb
    import enc_pkg::*;
#(
    parameter int P_CNT_W  = CNT_W_DEF,
    parameter int P_DROP_W = 16
) (
    input  logic                CLK,
    input  logic                I_RST,
    input  logic                I_ARM,
    input  logic [P_CNT_W-1:0]  I_CNT0,
    input  logic                I_RDY0,
    input  logic                I_OVF0,
    input  logic [P_CNT_W-1:0]  I_CNT1,
    input  logic                I_RDY1,
    input  logic                I_OVF1,
    output logic                O_VALID,
    input  logic                I_READY,
    output logic [P_CNT_W-1:0]  O_DATA,
    output logic                O_CH,
    output logic                O_OVF,
    output logic [P_DROP_W-1:0] O_DROP0,
    output logic [P_DROP_W-1:0] O_DROP1,
    output logic                O_BUSY
);

    logic               full0, full1;
    logic [P_CNT_W-1:0] sdata0, sdata1;
    logic               sovf0, sovf1;
    logic               take0, take1;

    logic               arm_prev_q, arm_prev_d;
    logic               arm_rise;
    logic               avail0, avail1, any_avail;
    logic               hs, load, sel;

    state_t             state_q, state_d;
    logic               vld_q, vld_d;
    logic [P_CNT_W-1:0] data_q, data_d;
    logic               ch_q, ch_d;
    logic               ovf_q, ovf_d;
    logic               last_q, last_d;

    enc_slot #(.CNT_W(P_CNT_W), .DROP_W(P_DROP_W)) u_slot0 (
        .clk(CLK), .rst(I_RST), .rdy(I_RDY0), .arm(I_ARM), .arm_rise(arm_rise),
        .take(take0), .snap_cnt(I_CNT0), .snap_ovf(I_OVF0),
        .full(full0), .data(sdata0), .ovf(sovf0), .drop(O_DROP0)
    );

    enc_slot #(.CNT_W(P_CNT_W), .DROP_W(P_DROP_W)) u_slot1 (
        .clk(CLK), .rst(I_RST), .rdy(I_RDY1), .arm(I_ARM), .arm_rise(arm_rise),
        .take(take1), .snap_cnt(I_CNT1), .snap_ovf(I_OVF1),
        .full(full1), .data(sdata1), .ovf(sovf1), .drop(O_DROP1)
    );

    // Slots are only eligible while armed, so a flush cycle never emits the flushed word.
    assign avail0    = full0 & I_ARM;
    assign avail1    = full1 & I_ARM;
    assign any_avail = avail0 | avail1;
    assign hs        = vld_q & I_READY;
    assign arm_rise  = I_ARM & ~arm_prev_q;
    assign arm_prev_d = I_ARM;

    // State register.
    always_ff @(posedge CLK) begin
        if (I_RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave IDLE when a slot is ready, return once the last word is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_avail) state_d = SEND;
            SEND:    if (hs && !any_avail) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output word selection, slot release and round-robin update.
    always_comb begin
        load = ((state_q == IDLE) && any_avail) || ((state_q == SEND) && hs && any_avail);
        if (avail0 && avail1) begin
            sel = ~last_q;
        end else begin
            sel = avail1 ? CH1 : CH0;
        end
        take0  = load && (sel == CH0);
        take1  = load && (sel == CH1);
        vld_d  = vld_q;
        data_d = data_q;
        ch_d   = ch_q;
        ovf_d  = ovf_q;
        last_d = last_q;
        if (load) begin
            vld_d  = 1'b1;
            data_d = (sel == CH1) ? sdata1 : sdata0;
            ovf_d  = (sel == CH1) ? sovf1 : sovf0;
            ch_d   = sel;
            last_d = sel;
        end else if (hs) begin
            vld_d = 1'b0;
        end
    end

    // Output and arbitration registers; last=CH1 after reset gives channel 0 first pick.
    always_ff @(posedge CLK) begin
        if (I_RST) begin
            vld_q      <= 1'b0;
            data_q     <= '0;
            ch_q       <= CH0;
            ovf_q      <= 1'b0;
            last_q     <= CH1;
            arm_prev_q <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            data_q     <= data_d;
            ch_q       <= ch_d;
            ovf_q      <= ovf_d;
            last_q     <= last_d;
            arm_prev_q <= arm_prev_d;
        end
    end

    assign O_VALID = vld_q;
    assign O_DATA  = data_q;
    assign O_CH    = ch_q;
    assign O_OVF   = ovf_q;
    assign O_BUSY  = full0 | full1 | vld_q;

endmodule

// File: tb/tb_enc_readout_arb.sv
module tb_enc_readout_arb;

    localparam int CW = 64;
    localparam int DW = 4;

    logic          CLK;
    logic          I_RST, I_ARM, I_READY;
    logic [CW-1:0] I_CNT0, I_CNT1;
    logic          I_RDY0, I_RDY1, I_OVF0, I_OVF1;
    logic          O_VALID, O_CH, O_OVF, O_BUSY;
    logic [CW-1:0] O_DATA;
    logic [DW-1:0] O_DROP0, O_DROP1;

    enc_readout_arb #(.P_CNT_W(CW), .P_DROP_W(DW)) dut (
        .CLK(CLK), .I_RST(I_RST), .I_ARM(I_ARM),
        .I_CNT0(I_CNT0), .I_RDY0(I_RDY0), .I_OVF0(I_OVF0),
        .I_CNT1(I_CNT1), .I_RDY1(I_RDY1), .I_OVF1(I_OVF1),
        .O_VALID(O_VALID), .I_READY(I_READY), .O_DATA(O_DATA),
        .O_CH(O_CH), .O_OVF(O_OVF), .O_DROP0(O_DROP0), .O_DROP1(O_DROP1),
        .O_BUSY(O_BUSY)
    );

    typedef struct packed {
        logic          ch;
        logic          ovf;
        logic [CW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic ch, input logic ovf, input logic [CW-1:0] d);
        exp_t e;
        e.ch = ch; e.ovf = ovf; e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        tick();
        I_RST = 1'b1;
        tick();
        I_RST = 1'b0;
    endtask

    // Monitor: every accepted word must match the next expected entry.
    always @(negedge CLK) begin
        if (!I_RST && O_VALID && I_READY) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_word", O_DATA, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_data", O_DATA, e.data);
                chk("sb_ch", O_CH, e.ch);
                chk("sb_ovf", O_OVF, e.ovf);
            end
        end
    end

    initial begin
        I_RST = 1'b1; I_ARM = 1'b0; I_READY = 1'b0;
        I_CNT0 = '0; I_CNT1 = '0; I_RDY0 = 0; I_RDY1 = 0; I_OVF0 = 0; I_OVF1 = 0;
        tick(); tick();
        I_RST = 1'b0; I_ARM = 1'b1; I_READY = 1'b1;

        // Reset state
        chk("rst_valid", O_VALID, 0);
        chk("rst_data", O_DATA, 0);
        chk("rst_busy", O_BUSY, 0);
        chk("rst_drop0", O_DROP0, 0);
        chk("rst_drop1", O_DROP1, 0);

        // Single word, two-cycle latency, one valid cycle
        tick(); tick();
        tick(); I_CNT0 = 1500; I_RDY0 = 1; push(0, 0, 1500);
        tick(); I_RDY0 = 0;
        chk("t1_valid_n1", O_VALID, 0);
        chk("t1_busy_n1", O_BUSY, 1);
        tick();
        chk("t1_valid_n2", O_VALID, 1);
        chk("t1_data_n2", O_DATA, 1500);
        tick();
        chk("t1_valid_n3", O_VALID, 0);
        chk("t1_busy_n3", O_BUSY, 0);

        // Simultaneous pulses after reset: ch0 first
        do_reset();
        tick(); I_CNT0 = 100; I_CNT1 = 200; I_RDY0 = 1; I_RDY1 = 1;
        push(0, 0, 100); push(1, 0, 200);
        tick(); I_RDY0 = 0; I_RDY1 = 0;
        chk("t2_valid_n1", O_VALID, 0);
        tick();
        chk("t2_valid_n2", O_VALID, 1);
        chk("t2_ch_n2", O_CH, 0);
        tick();
        chk("t2_valid_n3", O_VALID, 1);
        chk("t2_ch_n3", O_CH, 1);
        tick();
        chk("t2_valid_n4", O_VALID, 0);

        // Backpressure and overrun on ch0
        I_READY = 0;
        tick(); I_CNT0 = 10; I_RDY0 = 1; push(0, 0, 10);
        tick(); I_RDY0 = 0;
        tick(); I_CNT0 = 20; I_RDY0 = 1; push(0, 0, 20);
        tick(); I_RDY0 = 0;
        tick(); I_CNT0 = 30; I_RDY0 = 1;
        tick(); I_RDY0 = 0;
        chk("t3_hold_valid", O_VALID, 1);
        chk("t3_hold_data", O_DATA, 10);
        chk("t3_drop0", O_DROP0, 1);
        I_READY = 1;
        tick();
        chk("t3_second_data", O_DATA, 20);
        tick(); tick();
        chk("t3_idle", O_VALID, 0);
        chk("t3_drained", sb_q.size(), 0);

        // Fairness with both channels pulsing every cycle
        do_reset();
        push(0, 0, 1000); push(1, 0, 2000); push(0, 0, 1001); push(1, 0, 2002);
        push(0, 0, 1003); push(1, 0, 2004); push(0, 0, 1005);
        for (int k = 0; k < 6; k++) begin
            tick();
            I_RDY0 = 1; I_RDY1 = 1;
            I_CNT0 = 64'(1000 + k); I_CNT1 = 64'(2000 + k);
            if (k >= 2) chk("t4_no_gap", O_VALID, 1);
        end
        tick(); I_RDY0 = 0; I_RDY1 = 0;
        chk("t4_no_gap_c6", O_VALID, 1);
        tick(); chk("t4_no_gap_c7", O_VALID, 1);
        tick(); chk("t4_no_gap_c8", O_VALID, 1);
        tick(); chk("t4_end_valid", O_VALID, 0);
        chk("t4_drop0", O_DROP0, 2);
        chk("t4_drop1", O_DROP1, 3);

        // Disarm while stalled on a ch0 word with slot1 full
        I_READY = 0;
        tick(); I_CNT0 = 77; I_RDY0 = 1; push(0, 0, 77);
        tick(); I_RDY0 = 0; I_CNT1 = 88; I_RDY1 = 1;
        tick(); I_RDY1 = 0; I_ARM = 0;
        chk("t5_stall_valid", O_VALID, 1);
        chk("t5_stall_ch", O_CH, 0);
        tick(); I_RDY1 = 1;
        chk("t5_disarm_valid", O_VALID, 1);
        chk("t5_disarm_busy", O_BUSY, 1);
        tick(); I_RDY1 = 0;
        chk("t5_ignored_drop1", O_DROP1, 3);
        chk("t5_drop0_before", O_DROP0, 2);
        tick(); I_READY = 1;
        tick();
        chk("t5_after_valid", O_VALID, 0);
        chk("t5_after_busy", O_BUSY, 0);
        I_ARM = 1;
        tick();
        chk("t5_rise_drop0", O_DROP0, 0);
        chk("t5_rise_drop1", O_DROP1, 0);

        // Drop counter saturation, then reset mid-transfer
        I_READY = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            I_RDY1 = 1; I_OVF1 = 1; I_CNT1 = 64'(5000 + k);
        end
        tick(); I_RDY1 = 0; I_OVF1 = 0;
        chk("t6_drop1_sat", O_DROP1, 15);
        chk("t6_drop0", O_DROP0, 0);
        chk("t6_valid", O_VALID, 1);
        chk("t6_data", O_DATA, 5000);
        chk("t6_ch", O_CH, 1);
        chk("t6_ovf", O_OVF, 1);
        I_RST = 1;
        tick();
        I_RST = 0;
        chk("t6_rst_valid", O_VALID, 0);
        chk("t6_rst_data", O_DATA, 0);
        chk("t6_rst_ch", O_CH, 0);
        chk("t6_rst_ovf", O_OVF, 0);
        chk("t6_rst_drop1", O_DROP1, 0);
        chk("t6_rst_busy", O_BUSY, 0);

        tick(); tick();
        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/enc_readout_arb.md
Name: enc_readout_arb

Overview:
- Readout scheduler for the two-channel encoder counter (ENC_TOP).
- Captures each channel's count snapshot on that channel's ready pulse and holds it in a one-entry slot per channel.
- Arbitrates round-robin between the two slots onto a single valid/ready output stream toward the DAQ buffer.
- Counts snapshots lost to overrun, per channel.

Parameters:
- P_CNT_W, 64, width of count snapshot and O_DATA.
- P_DROP_W, 16, width of each saturating drop counter.

Ports:
- CLK  in  1  system clock (128 MHz); sole clock.
- I_RST  in  1  reset; synchronous, active-high.
- I_ARM  in  1  acquisition enable; low flushes pending slots.
- I_CNT0  in  P_CNT_W  channel 0 count snapshot.
- I_RDY0  in  1  one-cycle pulse; I_CNT0/I_OVF0 valid this cycle.
- I_OVF0  in  1  channel 0 overflow flag, sampled with I_RDY0.
- I_CNT1, I_RDY1, I_OVF1  in  P_CNT_W/1/1  channel 1 equivalents.
- O_VALID  out  1  output word valid.
- I_READY  in  1  downstream accepts; handshake = O_VALID & I_READY.
- O_DATA  out  P_CNT_W  count snapshot.
- O_CH  out  1  source channel (0/1).
- O_OVF  out  1  overflow flag captured with the snapshot.
- O_DROP0, O_DROP1  out  P_DROP_W  saturating per-channel drop counts.
- O_BUSY  out  1  high when any slot is full or O_VALID is high.

Behaviour:
- Reset (I_RST high at a CLK edge):
  - All outputs 0; slots empty; FSM IDLE.
  - Round-robin pointer gives channel 0 priority.
  - Reset mid-transfer drops O_VALID the next cycle without a handshake.
- Slot capture, per channel:
  - At a CLK edge with I_ARM=1, I_RDYx=1 and the slot empty: slot <= {I_CNTx, I_OVFx} and becomes full.
  - If the slot is full and not being loaded into the output this cycle: the new snapshot is discarded, the slot keeps the oldest value, and O_DROPx increments.
  - If the slot is being loaded into the output the same cycle: the new snapshot is captured and there is no drop.
- FSM has two states, IDLE and SEND.
  - IDLE: if any slot is full, select a channel, load O_DATA/O_CH/O_OVF from it, free that slot, go to SEND with O_VALID=1.
  - Selection: if only one slot is full, take it. If both are full, take the channel not served last.
  - SEND: O_DATA/O_CH/O_OVF/O_VALID stay stable until handshake.
  - On handshake with a slot full: load the next word in the same edge (back-to-back, stay in SEND).
  - On handshake with no slot full: clear O_VALID, go to IDLE.
- Latency: I_RDYx high in cycle N with the output idle gives O_VALID=1 in cycle N+2. Sustained throughput is one word per cycle.
- Round-robin pointer updates to the served channel on every load.
- I_ARM:
  - While I_ARM=0: I_RDYx is ignored (no capture, no drop count) and both slots are cleared.
  - An in-flight output word is never withdrawn; it stays valid until accepted.
  - On an I_ARM rising edge (registered previous value 0, current 1): O_DROP0 and O_DROP1 clear to 0.
- Drop counters saturate at all-ones and never wrap.
- O_BUSY is registered-combinational: (slot0 full | slot1 full | O_VALID).

Decomposition:
- Shared package enc_pkg holds:
  - the FSM state enum {IDLE, SEND};
  - channel id constants CH0=0, CH1=1;
  - the default count width 64, shared with ENC_TOP.
- Natural sub-module: enc_slot, instantiated twice.
  - Contains the one-entry capture register, the full flag, and the saturating drop counter.
  - Inputs: rdy, arm, arm_rise, take.
  - Outputs: full, data, ovf, drop.

Test Plan:
- Single word: I_ARM=1, I_READY=1, I_CNT0=1500 with I_RDY0 pulse in cycle 10 -> O_VALID=1, O_DATA=1500, O_CH=0, O_OVF=0 in cycle 12 only; O_BUSY=0 from cycle 13.
- Simultaneous: after reset, I_RDY0 and I_RDY1 in the same cycle with counts 100/200, I_READY=1 -> two consecutive valid cycles, (200? no) order ch0=100 then ch1=200.
- Backpressure/drop: I_READY=0, I_RDY0 pulses with counts 10, 20, 30 two cycles apart -> O_DATA holds 10, slot holds 20, O_DROP0=1. Then I_READY=1 -> outputs 10, then 20; 30 never appears.
- Fairness: I_RDY0 and I_RDY1 pulsing every cycle, I_READY=1 -> O_CH alternates 0,1,0,1 with no gaps; both drop counters increment.
- ARM deassert mid-operation: output stalled on a ch0 word and slot1 full, then I_ARM=0 -> ch0 word stays valid until I_READY, ch1 word is never emitted, O_BUSY=0 after acceptance. Raising I_ARM -> O_DROP0/O_DROP1=0.
- Saturation and reset: P_DROP_W=4, 20 forced drops on ch1 -> O_DROP1=15. Then I_RST while O_VALID=1 -> all outputs 0 on the next cycle.
